wide_add_sequencer: RTL and testbench

Multi-cycle wide adder controller that time-shares one `sixteen_bit_FA` word adder to compute `(A + B + Cin)` over `NUM_WORDS` 16-bit words. It processes one word per clock, least-significant word first, and feeds each word's carry-out back as the next word's carry-in. It sits between a requester (start/done handshake) and the existing 16-bit ripple adder, letting the team add 32/64/128-bit operands without replicating adder hardware.

---
 rtl/adder_pkg.sv | 12 +
 rtl/sixteen_bit_FA.sv | 21 ++
 rtl/wide_add_sequencer.sv | 95 +++++++++
 tb/tb_wide_add_sequencer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the word-serial wide adder: shared adder width and sequencer states.
package adder_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } add_state_t;

endpackage

// File: rtl/sixteen_bit_FA.sv
// 16-bit ripple-carry adder; the single word adder that the wide sequencer time-shares.
module sixteen_bit_FA (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] S,
    output logic        Cout
);

    logic [16:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Cout = c[16];

endmodule

// File: rtl/wide_add_sequencer.sv
// Computes a + b + cin over NUM_WORDS 16-bit words, one word per clock, LSW first,
// reusing one sixteen_bit_FA and chaining its carry through a register.
module wide_add_sequencer
    import adder_pkg::*;
#(
    parameter int NUM_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [WORD_W*NUM_WORDS-1:0] a,
    input  logic [WORD_W*NUM_WORDS-1:0] b,
    input  logic                        cin,
    output logic                        busy,
    output logic                        done,
    output logic [WORD_W*NUM_WORDS-1:0] sum,
    output logic                        cout
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);

    add_state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic carry_q, cout_q;
    logic [NUM_WORDS-1:0][WORD_W-1:0] a_q, b_q, sum_q;

    logic accept, step;
    logic [WORD_W-1:0] fa_s;
    logic fa_cout;

    // Operand words are selected by idx from the latched copies, never from live inputs.
    sixteen_bit_FA u_fa (
        .A    (a_q[idx_q]),
        .B    (b_q[idx_q]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ADD;
                    accept  = 1'b1;
                end
            end
            ADD: begin
                step = 1'b1;
                if (idx_q == LAST) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= cin;
                idx_q   <= '0;
                sum_q   <= '0;
                cout_q  <= 1'b0;
            end
            if (step) begin
                sum_q[idx_q] <= fa_s;
                carry_q      <= fa_cout;
                // idx parks on the last word; the next accept rewinds it.
                if (idx_q == LAST) cout_q <= fa_cout;
                else               idx_q  <= idx_q + 1'b1;
            end
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed checks of the word-serial adder at 4 words and 1 word, with a result scoreboard.
module tb_wide_add_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start4 = 1'b0, cin4 = 1'b0;
    logic [63:0] a4 = '0, b4 = '0;
    logic        busy4, done4, cout4;
    logic [63:0] sum4;

    logic        start1 = 1'b0, cin1 = 1'b0;
    logic [15:0] a1 = '0, b1 = '0;
    logic        busy1, done1, cout1;
    logic [15:0] sum1;

    int tests = 0;
    int failed = 0;

    logic [64:0] exp_q4[$];
    logic [64:0] exp_q1[$];

    always #5 clk = ~clk;

    wide_add_sequencer #(.NUM_WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    wide_add_sequencer #(.NUM_WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives start for one edge; returns at the falling edge right after acceptance.
    task automatic issue4(input logic [63:0] a, input logic [63:0] b, input logic c);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
        exp_q4.push_back({1'b0, a} + {1'b0, b} + 65'(c));
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic issue1(input logic [15:0] a, input logic [15:0] b, input logic c);
        @(negedge clk);
        a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
        exp_q1.push_back(65'({1'b0, a} + {1'b0, b} + 17'(c)));
        @(negedge clk);
        start1 = 1'b0;
    endtask

    // Waits (bounded) for done, checks latency, busy length and the scoreboard result.
    task automatic wait_done(input string tag, input bit one, input int exp_lat, input int exp_busy);
        int lat;
        int bcnt;
        logic [64:0] want;
        lat  = 0;
        bcnt = (one ? busy1 : busy4) ? 1 : 0;
        while (!(one ? done1 : done4) && lat < 40) begin
            @(negedge clk);
            lat++;
            if (one ? busy1 : busy4) bcnt++;
        end
        check({tag, " latency"}, 65'(lat), 65'(exp_lat));
        if (one) want = exp_q1.size() > 0 ? exp_q1.pop_front() : 65'h0;
        else     want = exp_q4.size() > 0 ? exp_q4.pop_front() : 65'h0;
        check({tag, " result"}, one ? 65'({cout1, sum1}) : {cout4, sum4}, want);
        @(negedge clk);
        if (!(one ? busy1 : busy4)) lat = lat; else bcnt++;
        check({tag, " busy cycles"}, 65'(bcnt), 65'(exp_busy));
        check({tag, " done drop"}, 65'(one ? done1 : done4), 65'(0));
    endtask

    initial begin
        #12;
        check("reset busy", 65'(busy4), 65'(0));
        check("reset done", 65'(done4), 65'(0));
        check("reset sum/cout", {cout4, sum4}, 65'(0));
        @(negedge clk);
        rst_n = 1'b1;

        issue4(64'd11256, 64'd17958, 1'b1);
        wait_done("dec", 1'b0, 4, 5);
        check("dec sum", 65'(sum4), 65'd29215);

        issue4(64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
        wait_done("word carry", 1'b0, 4, 5);

        issue4(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        wait_done("full carry", 1'b0, 4, 5);
        check("full carry cout", 65'(cout4), 65'(1));

        // Starts at T0+2 and in DONE must be ignored; operand change must not matter.
        issue4(64'd24159, 64'd38967, 1'b0);
        @(negedge clk);
        a4 = 64'h1111; b4 = 64'h2222; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; a4 = 64'hDEAD_BEEF_0000_7777;
        @(negedge clk);
        @(negedge clk);
        check("ignore done", 65'(done4), 65'(1));
        check("ignore result", {cout4, sum4}, exp_q4.pop_front());
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("ignore done start", 65'(busy4), 65'(0));
        repeat (3) @(negedge clk);
        check("hold sum", 65'(sum4), 65'd63126);
        check("hold busy", 65'(busy4), 65'(0));

        // Asynchronous reset in the middle of an operation.
        issue4(64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 1'b0);
        @(posedge clk);
        #2;
        check("pre-reset word0", 65'(sum4[15:0]), 65'd2);
        rst_n = 1'b0;
        #1;
        check("async rst busy/done", 65'({busy4, done4}), 65'(0));
        check("async rst sum/cout", {cout4, sum4}, 65'(0));
        exp_q4.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue4(64'd1, 64'd2, 1'b0);
        wait_done("post reset", 1'b0, 4, 5);

        issue1(16'hFFFF, 16'h0001, 1'b1);
        wait_done("one word", 1'b1, 1, 2);
        check("one word cout", 65'(cout1), 65'(1));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
